// File: rtl/pair_filter_if.sv
// Pair filter stream interface: input pair handshake, output FIFO head and stats.
// The master modport is the producer/consumer side; the slave modport is the filter.
interface pair_filter_if #(
    parameter int unsigned DW    = 33,
    parameter int unsigned TAG_W = 24
);
    logic                in_valid;
    logic                in_ready;
    logic [DW-1:0]       in_dx;
    logic [DW-1:0]       in_dy;
    logic [DW-1:0]       in_dz;
    logic [TAG_W-1:0]    in_tag;
    logic [2*DW-1:0]     cutoff_sq;
    logic                out_valid;
    logic                out_ready;
    logic [DW-1:0]       out_dx;
    logic [DW-1:0]       out_dy;
    logic [DW-1:0]       out_dz;
    logic [2*DW+1:0]     out_r2;
    logic [TAG_W-1:0]    out_tag;
    logic [31:0]         pairs_in;
    logic [31:0]         pairs_kept;

    modport master (
        output in_valid, in_dx, in_dy, in_dz, in_tag, cutoff_sq, out_ready,
        input  in_ready, out_valid, out_dx, out_dy, out_dz, out_r2, out_tag,
               pairs_in, pairs_kept
    );

    modport slave (
        input  in_valid, in_dx, in_dy, in_dz, in_tag, cutoff_sq, out_ready,
        output in_ready, out_valid, out_dx, out_dy, out_dz, out_r2, out_tag,
               pairs_in, pairs_kept
    );
endinterface

// File: rtl/pair_filter.sv
// Pair filter: 4-stage r^2 pipeline (register, square, sum, compare) feeding a
// credit-protected output FIFO. Pairs with 0 < r^2 < cutoff^2 are kept.
// Optional statistics counters are built when PAIR_FILTER_STATS_EN is defined;
// otherwise pairs_in/pairs_kept are tied to 0.
module pair_filter #(
    parameter int unsigned DW         = 33,
    parameter int unsigned TAG_W      = 24,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input logic          clk,
    input logic          rst,
    pair_filter_if.slave bus
);
    localparam int unsigned R2W = 2 * DW + 2;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [DW-1:0]    dx;
        logic [DW-1:0]    dy;
        logic [DW-1:0]    dz;
        logic [TAG_W-1:0] tag;
        logic [2*DW-1:0]  cut;
    } stage_t;

    typedef struct packed {
        logic [DW-1:0]    dx;
        logic [DW-1:0]    dy;
        logic [DW-1:0]    dz;
        logic [TAG_W-1:0] tag;
        logic [R2W-1:0]   r2;
    } entry_t;

    logic s1_valid, s2_valid, s3_valid, s4_valid;
    stage_t s1_q, s2_q, s3_q, s4_q;
    logic [2*DW-1:0] s2_sqx, s2_sqy, s2_sqz;
    logic [R2W-1:0]  s3_r2, s4_r2;

    logic signed [2*DW-1:0] ext_x, ext_y, ext_z;
    logic [2*DW-1:0]        sq_x, sq_y, sq_z;
    logic [R2W-1:0]         r2_sum;

    entry_t          mem [FIFO_DEPTH];
    entry_t          head;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [2:0]      inflight;
    logic [CW:0]     occupancy;
    logic            in_ready_int, out_valid_int;
    logic            accept, keep, push, pop;

    // Credit check: FIFO entries plus pairs still in flight must leave room.
    always_comb begin
        inflight     = {2'b00, s1_valid} + {2'b00, s2_valid}
                     + {2'b00, s3_valid} + {2'b00, s4_valid};
        occupancy    = {1'b0, count} + (CW + 1)'(inflight);
        in_ready_int = !rst && (occupancy < DEPTH_V);
        accept       = bus.in_valid && in_ready_int;
    end

    // Squares are computed at full width so the most-negative input is exact.
    always_comb begin
        ext_x  = {{DW{s1_q.dx[DW-1]}}, s1_q.dx};
        ext_y  = {{DW{s1_q.dy[DW-1]}}, s1_q.dy};
        ext_z  = {{DW{s1_q.dz[DW-1]}}, s1_q.dz};
        sq_x   = ext_x * ext_x;
        sq_y   = ext_y * ext_y;
        sq_z   = ext_z * ext_z;
        r2_sum = {2'b00, s2_sqx} + {2'b00, s2_sqy} + {2'b00, s2_sqz};
    end

    // Keep decision at S4; the zero check rejects self pairs.
    always_comb begin
        keep          = (s4_r2 != '0) && (s4_r2 < {2'b00, s4_q.cut});
        push          = s4_valid && keep;
        out_valid_int = (count != '0);
        pop           = out_valid_int && bus.out_ready;
    end

    // Pipeline never stalls; only the valid bits need reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s4_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            s4_valid <= s3_valid;
        end
        s1_q.dx  <= bus.in_dx;
        s1_q.dy  <= bus.in_dy;
        s1_q.dz  <= bus.in_dz;
        s1_q.tag <= bus.in_tag;
        s1_q.cut <= bus.cutoff_sq;
        s2_q     <= s1_q;
        s2_sqx   <= sq_x;
        s2_sqy   <= sq_y;
        s2_sqz   <= sq_z;
        s3_q     <= s2_q;
        s3_r2    <= r2_sum;
        s4_q     <= s3_q;
        s4_r2    <= s3_r2;
    end

    // FIFO storage; credits guarantee a push never lands on a full FIFO.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{dx: s4_q.dx, dy: s4_q.dy, dz: s4_q.dz,
                             tag: s4_q.tag, r2: s4_r2};
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head is masked to zero while the FIFO is empty so stale storage never shows.
    assign head          = mem[rd_ptr];
    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.out_dx    = out_valid_int ? head.dx  : '0;
    assign bus.out_dy    = out_valid_int ? head.dy  : '0;
    assign bus.out_dz    = out_valid_int ? head.dz  : '0;
    assign bus.out_r2    = out_valid_int ? head.r2  : '0;
    assign bus.out_tag   = out_valid_int ? head.tag : '0;

`ifdef PAIR_FILTER_STATS_EN
    logic [31:0] pairs_in_q, pairs_kept_q;

    // Saturating accept/push counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            pairs_in_q   <= '0;
            pairs_kept_q <= '0;
        end else begin
            if (accept && (pairs_in_q != '1)) pairs_in_q <= pairs_in_q + 1'b1;
            if (push && (pairs_kept_q != '1)) pairs_kept_q <= pairs_kept_q + 1'b1;
        end
    end

    assign bus.pairs_in   = pairs_in_q;
    assign bus.pairs_kept = pairs_kept_q;
`else
    assign bus.pairs_in   = '0;
    assign bus.pairs_kept = '0;
`endif
endmodule

// File: tb/tb_pair_filter.sv
// Testbench for pair_filter: directed scenarios plus random traffic, all checked
// each cycle against a queue-based model of accepted pairs.
module tb_pair_filter;
    localparam int unsigned DW    = 33;
    localparam int unsigned TAG_W = 24;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned R2W   = 2 * DW + 2;
`ifdef PAIR_FILTER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pair_filter_if #(.DW(DW), .TAG_W(TAG_W)) bus ();

    pair_filter #(.DW(DW), .TAG_W(TAG_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [R2W-1:0] act,
                         input logic [R2W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every accepted pair in arrival order, tagged with its accept edge.
    typedef struct {
        logic [DW-1:0]    dx;
        logic [DW-1:0]    dy;
        logic [DW-1:0]    dz;
        logic [TAG_W-1:0] tag;
        logic [R2W-1:0]   r2;
        bit               keep;
        int               t_acc;
    } pair_t;

    pair_t       live[$];
    int          cyc = 0;
    logic [31:0] m_in = 0;
    logic [31:0] m_kept = 0;
    bit          model_on = 1'b0;

    function automatic logic [R2W-1:0] sq(input logic [DW-1:0] d);
        logic signed [R2W-1:0] v;
        v = R2W'($signed(d));
        return v * v;
    endfunction

    // Head of the FIFO: oldest kept pair, visible 4 edges after its accept.
    function automatic int head_idx();
        for (int i = 0; i < live.size(); i++) begin
            if (live[i].keep) return (cyc >= live[i].t_acc + 4) ? i : -1;
        end
        return -1;
    endfunction

    // Credits held: kept pairs until popped, dropped pairs until they leave S4.
    function automatic int live_cnt();
        int n = 0;
        for (int i = 0; i < live.size(); i++) begin
            if (live[i].keep || cyc < live[i].t_acc + 4) n++;
        end
        return n;
    endfunction

    int    h;
    bit    ev, er;
    pair_t e, p;

    always @(negedge clk) begin
        if (model_on) begin
            h  = head_idx();
            ev = (h >= 0);
            er = !rst && (live_cnt() < DEPTH);
            check("in_ready", bus.in_ready, er);
            check("out_valid", bus.out_valid, ev);
            if (ev) begin
                e = live[h];
                check("out_dx", bus.out_dx, e.dx);
                check("out_dy", bus.out_dy, e.dy);
                check("out_dz", bus.out_dz, e.dz);
                check("out_r2", bus.out_r2, e.r2);
                check("out_tag", bus.out_tag, e.tag);
            end
            check("pairs_in", bus.pairs_in, STATS ? m_in : 32'd0);
            check("pairs_kept", bus.pairs_kept, STATS ? m_kept : 32'd0);
            // Advance the model across the coming rising edge.
            cyc++;
            if (rst) begin
                live.delete();
                m_in   = 0;
                m_kept = 0;
            end else begin
                if (ev && bus.out_ready) live.delete(h);
                for (int i = live.size() - 1; i >= 0; i--) begin
                    if (!live[i].keep && cyc >= live[i].t_acc + 4) live.delete(i);
                end
                for (int i = 0; i < live.size(); i++) begin
                    if (live[i].keep && live[i].t_acc + 4 == cyc && m_kept != 32'hFFFF_FFFF)
                        m_kept++;
                end
                if (bus.in_valid && er) begin
                    p.dx    = bus.in_dx;
                    p.dy    = bus.in_dy;
                    p.dz    = bus.in_dz;
                    p.tag   = bus.in_tag;
                    p.r2    = sq(bus.in_dx) + sq(bus.in_dy) + sq(bus.in_dz);
                    p.keep  = (p.r2 != 0) && (p.r2 < {2'b00, bus.cutoff_sq});
                    p.t_acc = cyc;
                    live.push_back(p);
                    if (m_in != 32'hFFFF_FFFF) m_in++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pair(input logic [DW-1:0] dx, input logic [DW-1:0] dy,
                            input logic [DW-1:0] dz, input logic [TAG_W-1:0] tag);
        bus.in_dx  = dx;
        bus.in_dy  = dy;
        bus.in_dz  = dz;
        bus.in_tag = tag;
    endtask

    task automatic send(input logic [DW-1:0] dx, input logic [DW-1:0] dy,
                        input logic [DW-1:0] dz, input logic [TAG_W-1:0] tag);
        int n;
        bit took;
        n    = 0;
        took = 1'b0;
        set_pair(dx, dy, dz, tag);
        bus.in_valid = 1'b1;
        while (!took && n < 50) begin
            took = bus.in_ready;
            step();
            n++;
        end
        bus.in_valid = 1'b0;
        check("send_accepted", took, 1);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        step();
        check("rst_in_ready_low", bus.in_ready, 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready_back", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_r2", bus.out_r2, 0);
        check("rst_out_dx", bus.out_dx, 0);
        check("rst_out_tag", bus.out_tag, 0);
        check("rst_pairs_in", bus.pairs_in, 0);
        check("rst_pairs_kept", bus.pairs_kept, 0);
    endtask

    function automatic logic [DW-1:0] rnd_d();
        int v;
        case ($urandom_range(0, 11))
            0:       return 33'h1_0000_0000;
            1:       return 33'h0_FFFF_FFFF;
            default: begin
                v = int'($urandom_range(0, 12)) - 6;
                return DW'(v);
            end
        endcase
    endfunction

    function automatic logic [2*DW-1:0] rnd_cut();
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return '0;
            2:       return 66'd1;
            3:       return 66'd50;
            4:       return 66'h3_0000_0000_0000_0000;
            default: return 66'd100;
        endcase
    endfunction

    int acc;
    int k;
    bit took;
    logic [2*DW-1:0] ones;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_dx     = '0;
        bus.in_dy     = '0;
        bus.in_dz     = '0;
        bus.in_tag    = '0;
        bus.cutoff_sq = '0;
        bus.out_ready = 1'b0;
        step();
        model_on = 1'b1;
        do_reset();

        // Basic keep: (3,4,0) -> r2 = 25 at the head 4 edges after accept.
        bus.cutoff_sq = 66'd100;
        send(3, 4, 0, 24'h000102);
        repeat (3) step();
        check("basic_not_yet", bus.out_valid, 0);
        step();
        check("basic_valid", bus.out_valid, 1);
        check("basic_r2", bus.out_r2, 25);
        check("basic_tag", bus.out_tag, 24'h000102);
        check("basic_kept", bus.pairs_kept, STATS ? 32'd1 : 32'd0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("basic_popped", bus.out_valid, 0);

        // Boundaries: r2 == cutoff, r2 == 0, negative pair on the cutoff.
        do_reset();
        bus.cutoff_sq = 66'd100;
        send(10, 0, 0, 24'h1);
        send(0, 0, 0, 24'h2);
        send(-6, -8, 0, 24'h3);
        repeat (6) step();
        check("bound_pairs_in", bus.pairs_in, STATS ? 32'd3 : 32'd0);
        check("bound_pairs_kept", bus.pairs_kept, 0);
        check("bound_out_valid", bus.out_valid, 0);

        // Backpressure: stream 20 keepable pairs into a stalled consumer.
        do_reset();
        bus.cutoff_sq = 66'd1000;
        acc = 0;
        k   = 0;
        set_pair(1, 1, 0, 0);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            took = bus.in_ready;
            step();
            if (took) begin
                acc++;
                k++;
                set_pair(DW'(k + 1), 1, 0, TAG_W'(k));
            end
        end
        check("bp_accepted", acc, DEPTH);
        check("bp_in_ready_low", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        check("bp_head_dx", bus.out_dx, 1);
        took = bus.in_ready;
        step();
        check("bp_ready_after_pop", bus.in_ready, 1);
        for (int c = 0; c < 200 && k < 20; c++) begin
            took = bus.in_ready;
            step();
            if (took) begin
                k++;
                set_pair(DW'(k + 1), 1, 0, TAG_W'(k));
            end
        end
        bus.in_valid = 1'b0;
        check("bp_all_sent", k, 20);
        repeat (12) step();
        check("bp_drained", bus.out_valid, 0);
        bus.out_ready = 1'b0;

        // Extremes: 3 * (-2^32)^2 = 3*2^64 is below the all-ones 66-bit cutoff.
        do_reset();
        ones          = '1;
        bus.cutoff_sq = ones;
        send(33'h1_0000_0000, 33'h1_0000_0000, 33'h1_0000_0000, 24'hABCDEF);
        repeat (4) step();
        check("ext_valid", bus.out_valid, 1);
        check("ext_r2", bus.out_r2, 68'h3_0000_0000_0000_0000);
        check("ext_dx", bus.out_dx, 33'h1_0000_0000);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        // Same pair with the cutoff equal to its r2 is dropped.
        bus.cutoff_sq = 66'h3_0000_0000_0000_0000;
        send(33'h1_0000_0000, 33'h1_0000_0000, 33'h1_0000_0000, 24'hABCDEF);
        repeat (5) step();
        check("ext_eq_dropped", bus.out_valid, 0);
        check("ext_pairs_kept", bus.pairs_kept, STATS ? 32'd1 : 32'd0);

        // Reset mid-stream discards everything in flight and buffered.
        do_reset();
        bus.cutoff_sq = 66'd100;
        for (int i = 0; i < 5; i++) send(1, 2, DW'(i), TAG_W'(i));
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("mid_out_valid", bus.out_valid, 0);
        check("mid_pairs_in", bus.pairs_in, 0);
        check("mid_pairs_kept", bus.pairs_kept, 0);
        repeat (8) step();
        check("mid_nothing_emerges", bus.out_valid, 0);
        send(2, 2, 1, 24'h55);
        repeat (3) step();
        check("mid_next_not_yet", bus.out_valid, 0);
        step();
        check("mid_next_valid", bus.out_valid, 1);
        check("mid_next_r2", bus.out_r2, 9);
        check("mid_next_tag", bus.out_tag, 24'h55);

        // Random traffic against the model.
        do_reset();
        bus.cutoff_sq = 66'd100;
        for (int c = 0; c < 1500; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            set_pair(rnd_d(), rnd_d(), rnd_d(), TAG_W'($urandom));
            bus.out_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 15) == 0) bus.cutoff_sq = rnd_cut();
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (12) step();
        check("final_drained", bus.out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
